elevator_motion_ctrl: RTL and testbench
=======================================

// Module: elevator_motion_ctrl
// PURPOSE
//  Sequences the elevator car between 4 floors. Consumes the head-of-queue destination (des) and go flag from the request queue.
//  Produces the one-hot current floor (cs) that the queue samples, plus motion and door status.
//  Travel and door dwell are timed in slow-clock ticks.
// PARAMETERS
//  TRAVEL_TICKS  4  ticks needed to move one floor (>=1)
//  DOOR_TICKS    6  ticks the door stays open (>=1)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst_n      in   1  synchronous, active-low reset
//  tick       in   1  1-clk enable pulse from slow clock divider
//  go         in   1  queue has an unserved request
//  des        in   4  one-hot target floor; 4'b1111 = queue empty
//  door_hold  in   1  hold-door button (only with ELEVATOR_DOOR_HOLD_EN)
//  cs         out  4  one-hot current floor, 4'b0001 = floor 1
//  moving     out  1  car travelling
//  dir_up     out  1  1 = up, 0 = down; valid while moving
//  door_open  out  1  door open
//  arrived    out  1  1-clk pulse when the car reaches the latched target
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, cs=4'b0001, tgt=4'b0001, timer=0; all other outputs 0. Mid-operation reset abandons the trip.
//  des is valid only if one-hot. 4'b1111 and any other non-one-hot value are ignored.
//  IDLE: on a clk with go=1 and valid des:
//   - des==cs: go to DOOR, timer=0.
//   - otherwise latch tgt=des, dir_up=(des>cs), go to MOVE, timer=0.
//   - tick is not required for this decision.
//  MOVE: moving=1. Timer increments only on tick. On a tick with timer==TRAVEL_TICKS-1:
//   - cs shifts left 1 bit if dir_up, else right 1 bit; timer=0.
//   - if new cs==tgt: go to DOOR, arrived=1 for that clk.
//  des changes during MOVE are ignored; tgt holds until arrival.
//  Guard: a shift never leaves the range 4'b0001..4'b1000. If cs is at an end floor and the shift would overflow, go to DOOR with no arrived pulse.
//  DOOR: door_open=1, moving=0. Timer increments on tick. On a tick with timer==DOOR_TICKS-1: go to IDLE, timer=0.
//  State encoding is 2 bits: IDLE=0, MOVE=1, DOOR=2. An illegal state recovers to IDLE on the next clk.
//  All outputs are registered, so cs changes exactly 1 clk after the qualifying tick edge.
//  Timer width is clog2(max(TRAVEL_TICKS, DOOR_TICKS)) + 1. The timer never wraps; it is cleared on every state change.
// CONFIGURATION
//  ELEVATOR_DOOR_HOLD_EN defined:
//   - door_hold port exists.
//   - door_hold=1 in DOOR clears timer each clk, so the door stays open while held.
//   - door_hold=1 in IDLE with valid des==cs re-enters DOOR.
//  ELEVATOR_DOOR_HOLD_EN undefined: port absent; door always closes after DOOR_TICKS ticks.
// TESTING
//  1. Reset then idle, go=0, 20 ticks -> cs=4'b0001, moving=0, door_open=0, busy=0.
//  2. des=4'b0100, go=1 at floor 1 -> dir_up=1; cs=4'b0010 after 4 ticks, cs=4'b0100 after 8 ticks; arrived pulses once; door_open for 6 ticks; then IDLE.
//  3. At floor 3, des=4'b0001 -> dir_up=0; cs steps 0100->0010->0001 every 4 ticks; arrived pulses on the final step.
//  4. Mid-MOVE, des changes 4'b1000->4'b0010 -> car still stops at 4'b1000 (tgt latched).
//  5. des=4'b1111 or 4'b0110 with go=1 -> stays IDLE; cs unchanged.
//  6. rst_n=0 during MOVE at cs=4'b0100 -> next clk: cs=4'b0001, IDLE, moving=0.
//     With ELEVATOR_DOOR_HOLD_EN: door_hold=1 for 10 ticks during DOOR -> door_open stays 1 until 6 ticks after release.

Source files
------------

// File: rtl/elevator_motion_ctrl.sv
// Four-floor elevator car sequencer: IDLE -> MOVE -> DOOR, timed in slow-clock ticks.
// Optional feature macro: ELEVATOR_DOOR_HOLD_EN (adds door_hold input).
module elevator_motion_ctrl #(
  parameter int unsigned TRAVEL_TICKS = 4,
  parameter int unsigned DOOR_TICKS   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       go,
  input  logic [3:0] des,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic [3:0] cs,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic       arrived,
  output logic       busy
);

  localparam int unsigned TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cs_q, cs_d;
  logic [3:0]    tgt_q, tgt_d;
  logic          dir_up_q, dir_up_d;
  logic          arrived_q, arrived_d;
  logic          moving_q, moving_d;
  logic          door_open_q, door_open_d;
  logic          busy_q, busy_d;
  logic          des_valid;
  logic          hold;

  always_comb begin
`ifdef ELEVATOR_DOOR_HOLD_EN
    hold = door_hold;
`else
    hold = 1'b0;
`endif
  end

  assign des_valid = (des != 4'b0000) && ((des & (des - 4'd1)) == 4'b0000);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cs_d      = cs_q;
    tgt_d     = tgt_q;
    dir_up_d  = dir_up_q;
    arrived_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (des_valid && (des == cs_q) && (go || hold)) begin
          state_d = DOOR;
          timer_d = '0;
        end else if (des_valid && go && (des != cs_q)) begin
          state_d  = MOVE;
          timer_d  = '0;
          tgt_d    = des;
          dir_up_d = (des > cs_q);
        end
      end
      MOVE: begin
        if (tick) begin
          if (timer_q == TRAVEL_LAST) begin
            timer_d = '0;
            // End-floor guard: stop with the door rather than shifting out of range.
            if (dir_up_q ? cs_q[3] : cs_q[0]) begin
              state_d = DOOR;
            end else begin
              cs_d = dir_up_q ? (cs_q << 1) : (cs_q >> 1);
              if (cs_d == tgt_q) begin
                state_d   = DOOR;
                arrived_d = 1'b1;
              end
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      DOOR: begin
        if (hold) begin
          timer_d = '0;
        end else if (tick) begin
          if (timer_q == DOOR_LAST) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    moving_d    = (state_d == MOVE);
    door_open_d = (state_d == DOOR);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cs_q        <= 4'b0001;
      tgt_q       <= 4'b0001;
      dir_up_q    <= 1'b0;
      arrived_q   <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cs_q        <= cs_d;
      tgt_q       <= tgt_d;
      dir_up_q    <= dir_up_d;
      arrived_q   <= arrived_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      busy_q      <= busy_d;
    end
  end

  assign cs        = cs_q;
  assign moving    = moving_q;
  assign dir_up    = dir_up_q;
  assign door_open = door_open_q;
  assign arrived   = arrived_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl; floor changes are checked against a queue of expected floors.
module tb_elevator_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       go = 1'b0;
  logic [3:0] des = 4'b1111;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  logic [3:0] cs;
  logic       moving, dir_up, door_open, arrived, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned arrived_cnt = 0;
  logic [3:0]  cs_prev = 4'b0001;
  logic [3:0]  exp_q[$];

  elevator_motion_ctrl #(.TRAVEL_TICKS(4), .DOOR_TICKS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .go        (go),
    .des       (des),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .cs        (cs),
    .moving    (moving),
    .dir_up    (dir_up),
    .door_open (door_open),
    .arrived   (arrived),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Any floor change must match the next expected floor in the scoreboard.
  task automatic observe();
    logic [3:0] e;
    if (arrived === 1'b1) arrived_cnt++;
    if (cs !== cs_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_floor_change", {4'b0, cs}, {4'b0, cs_prev});
      end else begin
        e = exp_q.pop_front();
        chk("floor_step", {4'b0, cs}, {4'b0, e});
      end
      cs_prev = cs;
    end
  endtask

  task automatic clk1(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    observe();
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      clk1(1'b1);
      clk1(1'b0);
    end
  endtask

  task automatic request(input logic [3:0] d);
    des = d;
    go  = 1'b1;
    clk1(1'b0);
    go  = 1'b0;
    des = 4'b1111;
  endtask

  task automatic idle_flags(input string tag);
    chk({tag, "_moving"}, {7'b0, moving}, 8'd0);
    chk({tag, "_door"}, {7'b0, door_open}, 8'd0);
    chk({tag, "_busy"}, {7'b0, busy}, 8'd0);
  endtask

  initial begin
    int unsigned a0;

    // 1. reset and idle
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_cs", {4'b0, cs}, 8'h01);
    chk("rst_arrived", {7'b0, arrived}, 8'd0);
    chk("rst_dir", {7'b0, dir_up}, 8'd0);
    idle_flags("rst");
    ticks(20);
    chk("idle_cs", {4'b0, cs}, 8'h01);
    idle_flags("idle");

    // 2. floor 1 -> floor 3
    a0 = arrived_cnt;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    request(4'b0100);
    chk("up_moving", {7'b0, moving}, 8'd1);
    chk("up_dir", {7'b0, dir_up}, 8'd1);
    chk("up_busy", {7'b0, busy}, 8'd1);
    ticks(3);
    chk("up_3ticks_cs", {4'b0, cs}, 8'h01);
    ticks(1);
    chk("up_4ticks_cs", {4'b0, cs}, 8'h02);
    ticks(3);
    chk("up_no_early_arrive", 8'(arrived_cnt - a0), 8'd0);
    clk1(1'b1);
    chk("up_arrived_pulse", {7'b0, arrived}, 8'd1);
    chk("up_8ticks_cs", {4'b0, cs}, 8'h04);
    chk("up_door", {7'b0, door_open}, 8'd1);
    chk("up_moving_off", {7'b0, moving}, 8'd0);
    clk1(1'b0);
    chk("up_arrived_drop", {7'b0, arrived}, 8'd0);
    ticks(5);
    chk("door_5ticks", {7'b0, door_open}, 8'd1);
    ticks(1);
    idle_flags("door_closed");
    chk("up_arrive_count", 8'(arrived_cnt - a0), 8'd1);

    // 3. floor 3 -> floor 1
    a0 = arrived_cnt;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    request(4'b0001);
    chk("dn_dir", {7'b0, dir_up}, 8'd0);
    chk("dn_moving", {7'b0, moving}, 8'd1);
    ticks(4);
    chk("dn_4ticks_cs", {4'b0, cs}, 8'h02);
    ticks(4);
    chk("dn_8ticks_cs", {4'b0, cs}, 8'h01);
    chk("dn_arrive_count", 8'(arrived_cnt - a0), 8'd1);
    ticks(6);
    idle_flags("dn_done");

    // 4. destination change mid-trip is ignored
    a0 = arrived_cnt;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    request(4'b1000);
    des = 4'b0010;
    go  = 1'b1;
    ticks(12);
    go  = 1'b0;
    des = 4'b1111;
    chk("latch_cs", {4'b0, cs}, 8'h08);
    chk("latch_door", {7'b0, door_open}, 8'd1);
    chk("latch_arrive_count", 8'(arrived_cnt - a0), 8'd1);
    ticks(6);
    idle_flags("latch_done");

    // 5. invalid destinations are ignored
    request(4'b1111);
    ticks(2);
    chk("empty_cs", {4'b0, cs}, 8'h08);
    idle_flags("empty");
    request(4'b0110);
    ticks(2);
    chk("multi_cs", {4'b0, cs}, 8'h08);
    idle_flags("multi");
    request(4'b0000);
    ticks(2);
    idle_flags("zero");

    // request for the current floor opens the door without travel
    a0 = arrived_cnt;
    request(4'b1000);
    chk("same_door", {7'b0, door_open}, 8'd1);
    chk("same_moving", {7'b0, moving}, 8'd0);
`ifdef ELEVATOR_DOOR_HOLD_EN
    door_hold = 1'b1;
    ticks(10);
    door_hold = 1'b0;
    chk("hold_door", {7'b0, door_open}, 8'd1);
    ticks(5);
    chk("hold_release_5", {7'b0, door_open}, 8'd1);
    ticks(1);
    chk("hold_release_6", {7'b0, door_open}, 8'd0);
`else
    ticks(6);
`endif
    idle_flags("same_done");
    chk("same_no_arrive", 8'(arrived_cnt - a0), 8'd0);

    // 6. reset mid-trip at floor 3
    exp_q.push_back(4'b0100);
    request(4'b0001);
    ticks(6);
    chk("mid_cs", {4'b0, cs}, 8'h04);
    chk("mid_moving", {7'b0, moving}, 8'd1);
    exp_q.push_back(4'b0001);
    rst_n = 1'b0;
    clk1(1'b0);
    rst_n = 1'b1;
    chk("midrst_cs", {4'b0, cs}, 8'h01);
    idle_flags("midrst");

    // timer restarts cleanly after the abandoned trip
    exp_q.push_back(4'b0010);
    request(4'b0010);
    ticks(3);
    chk("post_rst_3ticks", {4'b0, cs}, 8'h01);
    ticks(1);
    chk("post_rst_4ticks", {4'b0, cs}, 8'h02);
    chk("post_rst_door", {7'b0, door_open}, 8'd1);
    ticks(6);
    idle_flags("post_rst_done");

    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
